mini_fir_cfg_seq: RTL and testbench
===================================

Name: mini_fir_cfg_seq

Overview:
- Configuration sequencer that programs the FIR coefficient/control register file over its simple register bus.
- On a start command it:
  - disables the filter by writing 0x00 to the FIR_CTRL register;
  - streams NUM_TAPS coefficients from a ready/valid source into coefficient registers 0..NUM_TAPS-1;
  - writes the requested control byte to FIR_CTRL.
- Sits between the system/host control logic and the FIR register file. It is the only bus master while busy.

Parameters:
- NUM_TAPS, 7: number of coefficient registers, at addresses 0..NUM_TAPS-1. Legal range 1..15.
- DATA_W, 8: register data width.
- ADDR_W, 4: register address width.
- CTRL_ADDR, 4'hF: address of the FIR_CTRL register.
- TIMEOUT_CYC, 255: maximum consecutive cycles waiting for a coefficient before aborting. Counter width is clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle start request; honoured only in IDLE
- i_ctrl_val  in  DATA_W  FIR_CTRL value written at the end of the sequence; sampled at start
- i_coeff_valid  in  1  coefficient source valid
- i_coeff_data  in  DATA_W  coefficient value
- o_coeff_ready  out  1  coefficient accept; a transfer occurs when valid && ready
- o_addr  out  ADDR_W  register bus address
- o_data_wr  out  DATA_W  register bus write data
- o_wr  out  1  register bus write strobe, one cycle per write
- o_rd  out  1  register bus read strobe (verify only; tied 0 otherwise)
- i_data_rd  in  DATA_W  combinational read data, valid in the same cycle as o_rd
- o_busy  out  1  high from the cycle after an accepted start until the cycle DONE is entered
- o_done  out  1  one-cycle pulse when the sequence ends (success or error)
- o_err  out  1  sticky error flag; cleared by the next accepted start

Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - tap counter, timeout counter and the latched ctrl value all 0.
- State machine:
  - IDLE:
    - i_start=1 latches i_ctrl_val, clears o_err and goes to DIS.
  - DIS (1 cycle):
    - drives o_addr=CTRL_ADDR, o_data_wr=0, o_wr=1;
    - goes to LOAD with tap=0.
  - LOAD:
    - o_coeff_ready=1, o_addr=tap, o_data_wr=i_coeff_data, o_wr=i_coeff_valid. This is a zero-latency pass-through; a write occurs in the same cycle as the handshake.
    - On a handshake: tap increments and the timeout counter clears.
    - On the handshake with tap=NUM_TAPS-1: go to CTRL.
    - No valid: the timeout counter increments. When it reaches TIMEOUT_CYC, set o_err and go to DONE. FIR_CTRL stays 0 (filter left disabled).
  - CTRL (1 cycle):
    - o_addr=CTRL_ADDR, o_data_wr=latched ctrl value, o_wr=1;
    - goes to VERIFY when the macro is defined, else to DONE.
  - DONE (1 cycle):
    - o_done=1, then go to IDLE.
- Bus rules:
  - o_wr and o_rd are never high together.
  - o_addr and o_data_wr are 0 whenever o_wr=0 and o_rd=0.
  - Exactly NUM_TAPS+2 writes per successful run.
- Fixed latency with an always-valid source: start to o_done = NUM_TAPS+3 cycles. The done pulse comes NUM_TAPS+3 cycles after the start cycle.
- Boundary and conflict cases:
  - i_start while busy: ignored, no effect.
  - i_start in the DONE cycle: ignored.
  - i_coeff_valid outside LOAD: ignored; o_coeff_ready stays 0.
- Reset mid-sequence: immediate return to IDLE with all outputs 0. Partially written registers are not restored; the register file is reset by the same rst_n.

Optional Feature:
- Macro: MINI_FIR_CFG_VERIFY_EN.
- Defined:
  - Each accepted coefficient is also stored in a NUM_TAPS x DATA_W shadow array.
  - State VERIFY runs NUM_TAPS+1 cycles after CTRL. Each cycle it drives o_rd=1, o_addr=tap 0..NUM_TAPS-1, then CTRL_ADDR.
  - Each i_data_rd is compared with the shadow value or the latched ctrl value. Any mismatch sets o_err. All reads are always performed.
  - Then go to DONE. Latency becomes 2*NUM_TAPS+4 cycles.
- Not defined:
  - No shadow array and no VERIFY state.
  - o_rd is tied 0 and i_data_rd is unused.

Decomposition:
- Package mini_fir_pkg holds:
  - the state enum (IDLE, DIS, LOAD, CTRL, VERIFY, DONE);
  - COEFF_BASE_ADDR=4'h0 and FIR_CTRL_ADDR=4'hF, shared with the register file;
  - DATA_W/ADDR_W defaults.
- Sub-module: one natural sub-module, mini_fir_cfg_timeout. It is the stall counter: clear/enable in, expire pulse out.

Test Plan:
- Always-valid source, coeffs 0x11..0x77, i_ctrl_val=0x81 -> bus writes are F:00, 0:11, 1:22 … 6:77, F:81. o_done at cycle 10 after start, o_err=0, register file holds these values.
- Source with valid toggling every other cycle -> the same 9 writes with gaps; o_wr only on handshake cycles; o_done after 17 cycles; no error.
- Source stalls after 3 coeffs for 255 cycles -> o_err=1 and o_done pulse; FIR_CTRL reads 0x00; registers 0..2 written, 3..6 unchanged.
- i_start pulsed again mid-LOAD, and a second i_start in the DONE cycle -> both ignored; exactly 9 writes and one o_done.
- rst_n asserted during LOAD at tap 4 -> outputs 0 and IDLE immediately. A new start then runs a clean full sequence.
- With MINI_FIR_CFG_VERIFY_EN: run 1, then force a read mismatch at address 3 via a bench-corrupted i_data_rd -> 8 reads occur; o_err=1; o_done at cycle 18.

Source files
------------

// File: rtl/mini_fir_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mini_fir_pkg
// Brief    : Shared types and addresses for the mini FIR register file and
//            its configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mini_fir_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam logic [3:0] COEFF_BASE_ADDR = 4'h0;
    localparam logic [3:0] FIR_CTRL_ADDR   = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIS    = 3'd1,
        LOAD   = 3'd2,
        CTRL   = 3'd3,
        VERIFY = 3'd4,
        DONE   = 3'd5
    } cfg_state_t;

endpackage
`default_nettype wire

// File: rtl/mini_fir_cfg_timeout.sv
`default_nettype none
// ============================================================================
// Module   : mini_fir_cfg_timeout
// Brief    : Stall counter; pulses o_expire on the TIMEOUT_CYC-th consecutive
//            enabled cycle since the last clear.
// Revision : 1.0 - initial release
// ============================================================================
module mini_fir_cfg_timeout #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expire = i_en && !i_clr && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/mini_fir_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : mini_fir_cfg_seq
// Brief    : Programs FIR coefficients and FIR_CTRL over the register bus.
//            Optional read-back check enabled by MINI_FIR_CFG_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mini_fir_cfg_seq
    import mini_fir_pkg::*;
#(
    parameter int                NUM_TAPS    = 7,
    parameter int                DATA_W      = DATA_W_DEF,
    parameter int                ADDR_W      = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(FIR_CTRL_ADDR),
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_ctrl_val,
    input  logic              i_coeff_valid,
    input  logic [DATA_W-1:0] i_coeff_data,
    output logic              o_coeff_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_wr,
    output logic              o_wr,
    output logic              o_rd,
    input  logic [DATA_W-1:0] i_data_rd,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    // One extra count so the verify pass can index FIR_CTRL after the last tap.
    localparam int TAP_W = $clog2(NUM_TAPS + 1);

    cfg_state_t        r_state;
    cfg_state_t        w_next;
    logic [TAP_W-1:0]  r_tap;
    logic [DATA_W-1:0] r_ctrl;
    logic              r_err;

    logic w_in_load;
    logic w_hs;
    logic w_tmo_clr;
    logic w_tmo_en;
    logic w_tmo_expire;
    logic w_last_tap;

    assign w_in_load  = (r_state == LOAD);
    assign w_hs       = w_in_load && i_coeff_valid;
    assign w_tmo_clr  = (r_state == DIS) || w_hs;
    assign w_tmo_en   = w_in_load && !i_coeff_valid;
    assign w_last_tap = (r_tap == TAP_W'(NUM_TAPS - 1));
    assign o_err      = r_err;

    mini_fir_cfg_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_tmo_expire)
    );

`ifdef MINI_FIR_CFG_VERIFY_EN
    logic [DATA_W-1:0] r_shadow [NUM_TAPS];
    logic [DATA_W-1:0] w_vfy_exp;
    logic              w_vfy_last;
    logic              w_vfy_mismatch;

    assign w_vfy_last     = (r_tap == TAP_W'(NUM_TAPS));
    assign w_vfy_exp      = w_vfy_last ? r_ctrl : r_shadow[r_tap];
    assign w_vfy_mismatch = (i_data_rd != w_vfy_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_hs) begin
            r_shadow[r_tap] <= i_coeff_data;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^i_data_rd;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_coeff_ready = 1'b0;
        o_addr        = '0;
        o_data_wr     = '0;
        o_wr          = 1'b0;
        o_rd          = 1'b0;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next = DIS;
                end
            end
            DIS: begin
                o_busy = 1'b1;
                o_wr   = 1'b1;
                o_addr = CTRL_ADDR;
                w_next = LOAD;
            end
            LOAD: begin
                o_busy        = 1'b1;
                o_coeff_ready = 1'b1;
                if (i_coeff_valid) begin
                    o_wr      = 1'b1;
                    o_addr    = ADDR_W'(COEFF_BASE_ADDR) + ADDR_W'(r_tap);
                    o_data_wr = i_coeff_data;
                    if (w_last_tap) begin
                        w_next = CTRL;
                    end
                end else if (w_tmo_expire) begin
                    w_next = DONE;
                end
            end
            CTRL: begin
                o_busy    = 1'b1;
                o_wr      = 1'b1;
                o_addr    = CTRL_ADDR;
                o_data_wr = r_ctrl;
`ifdef MINI_FIR_CFG_VERIFY_EN
                w_next    = VERIFY;
`else
                w_next    = DONE;
`endif
            end
`ifdef MINI_FIR_CFG_VERIFY_EN
            VERIFY: begin
                o_busy = 1'b1;
                o_rd   = 1'b1;
                o_addr = w_vfy_last ? CTRL_ADDR
                                    : ADDR_W'(COEFF_BASE_ADDR) + ADDR_W'(r_tap);
                if (w_vfy_last) begin
                    w_next = DONE;
                end
            end
`endif
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap  <= '0;
            r_ctrl <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_ctrl <= i_ctrl_val;
                        r_err  <= 1'b0;
                    end
                end
                DIS:  r_tap <= '0;
                LOAD: begin
                    if (w_hs) begin
                        r_tap <= r_tap + TAP_W'(1);
                    end
                    if (w_tmo_expire) begin
                        r_err <= 1'b1;
                    end
                end
                CTRL: r_tap <= '0;
`ifdef MINI_FIR_CFG_VERIFY_EN
                VERIFY: begin
                    r_tap <= r_tap + TAP_W'(1);
                    if (w_vfy_mismatch) begin
                        r_err <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mini_fir_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mini_fir_cfg_seq
// Brief    : Self-checking bench for mini_fir_cfg_seq with a behavioural
//            register file and a transaction-level sequence model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mini_fir_cfg_seq;
    import mini_fir_pkg::*;

    localparam int N    = 7;
    localparam int T    = 255;
    localparam int MAXC = 600;
`ifdef MINI_FIR_CFG_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_ctrl_val = 8'h00;
    logic       i_coeff_valid = 1'b0;
    logic [7:0] i_coeff_data = 8'h00;
    logic       o_coeff_ready, o_wr, o_rd, o_busy, o_done, o_err;
    logic [3:0] o_addr;
    logic [7:0] o_data_wr;
    logic [7:0] i_data_rd;
    logic       corrupt = 1'b0;

    always #5 clk = ~clk;

    mini_fir_cfg_seq #(
        .NUM_TAPS(N), .DATA_W(8), .ADDR_W(4), .CTRL_ADDR(4'hF), .TIMEOUT_CYC(T)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_ctrl_val(i_ctrl_val),
        .i_coeff_valid(i_coeff_valid), .i_coeff_data(i_coeff_data),
        .o_coeff_ready(o_coeff_ready), .o_addr(o_addr), .o_data_wr(o_data_wr),
        .o_wr(o_wr), .o_rd(o_rd), .i_data_rd(i_data_rd), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    // Register file reset by the same rst_n; read data may be corrupted at address 3.
    logic [7:0] rf [16];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (o_wr) begin
            rf[o_addr] <= o_data_wr;
        end
    end
    assign i_data_rd = (o_rd ? rf[o_addr] : 8'h00) ^
                       ((corrupt && o_addr == 4'd3) ? 8'h40 : 8'h00);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({o_coeff_ready, o_wr, o_rd, o_busy, o_done, o_err, o_addr, o_data_wr});
    endfunction

    typedef struct {
        int         mode;     // 0 always valid, 1 toggling, 2 stall after 3, 3 random
        logic [7:0] ctrl;
        logic [7:0] cxor;
        bit         extra;    // extra start pulses mid-LOAD and in DONE
        bit         corr;
        int         rst_at;   // cycle to assert reset, -1 for none
        int         exp_done; // -1 means model only
        int         exp_err;
        int         exp_writes;
    } vec_t;

    typedef struct { int cyc; int addr; int data; } wr_t;

    wr_t        exp_wq[$];
    wr_t        act_wq[$];
    bit         vpat   [MAXC];
    bit         e_busy [MAXC];
    bit         e_ready[MAXC];
    logic [7:0] coeff  [N];

    // Transaction-level expectation: walk the source pattern phase by phase.
    task automatic model(input logic [7:0] ctrl, input bit corr,
                         output int done, output int err, output int reads);
        int c, taken, stall;
        bit aborted;
        exp_wq.delete();
        for (int i = 0; i < MAXC; i++) begin e_busy[i] = 0; e_ready[i] = 0; end
        exp_wq.push_back('{1, 15, 0});
        c = 2; taken = 0; stall = 0; aborted = 0;
        while (taken < N && !aborted && c < MAXC - 2*N - 10) begin
            e_ready[c] = 1;
            if (vpat[c]) begin
                exp_wq.push_back('{c, taken, int'(coeff[taken])});
                taken++;
                stall = 0;
            end else begin
                stall++;
                if (stall == T) aborted = 1;
            end
            c++;
        end
        if (aborted) begin
            err = 1; reads = 0;
        end else begin
            exp_wq.push_back('{c, 15, int'(ctrl)});
            c++;
            reads = VFY ? N + 1 : 0;
            c += reads;
            err = (VFY && corr) ? 1 : 0;
        end
        done = c;
        for (int i = 1; i < done; i++) e_busy[i] = 1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int widx, done_cyc, done_cnt, err_after, busy_bad, ready_bad, rule_bad;
        int rd_cnt, exp_done, exp_err, exp_reads, rf_bad, last;
        logic [7:0] exp_rf [16];
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int k = 0; k < N; k++)
            coeff[k] = (v.mode == 3) ? 8'($urandom) : (8'(8'h11 * (k + 1)) ^ v.cxor);
        for (int c = 0; c < MAXC; c++) begin
            case (v.mode)
                0: vpat[c] = 1'b1;
                1: vpat[c] = (c % 2) == 1;
                2: vpat[c] = (c <= 4);
                default: vpat[c] = ($urandom_range(0, 2) != 0);
            endcase
        end
        model(v.ctrl, v.corr, exp_done, exp_err, exp_reads);
        for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
        foreach (exp_wq[i]) exp_rf[exp_wq[i].addr] = 8'(exp_wq[i].data);
        act_wq.delete();
        widx = 0; done_cyc = -1; done_cnt = 0; err_after = -1;
        busy_bad = 0; ready_bad = 0; rule_bad = 0; rd_cnt = 0;
        corrupt = v.corr;
        last = (v.rst_at >= 0) ? v.rst_at : exp_done + 3;
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            i_start       = (c == 0) || (v.extra && (c == 5 || c == exp_done));
            i_ctrl_val    = (c == 0) ? v.ctrl : 8'($urandom);
            i_coeff_valid = vpat[c];
            i_coeff_data  = (widx < N) ? coeff[widx] : 8'hEE;
            if (c == v.rst_at) begin
                #1 rst_n = 1'b0;
                #1 chk({tag, "_rst_mid_outputs"}, outs(), 0);
                i_start = 1'b0; i_coeff_valid = 1'b0; corrupt = 1'b0;
                @(posedge clk); @(negedge clk);
                chk({tag, "_rst_hold_outputs"}, outs(), 0);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (o_wr) act_wq.push_back('{c, int'(o_addr), int'(o_data_wr)});
            if (o_rd) rd_cnt++;
            if (o_busy != e_busy[c]) busy_bad++;
            if (o_coeff_ready != e_ready[c]) ready_bad++;
            if (o_wr && o_rd) rule_bad++;
            if (!o_wr && !o_rd && (o_addr != 4'd0 || o_data_wr != 8'd0)) rule_bad++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == exp_done + 1) err_after = int'(o_err);
            if (i_coeff_valid && o_coeff_ready) widx++;
        end
        i_start = 1'b0; i_coeff_valid = 1'b0; corrupt = 1'b0;
        rf_bad = 0;
        for (int i = 0; i < 16; i++) if (rf[i] != exp_rf[i]) rf_bad++;
        chk({tag, "_write_count"}, act_wq.size(), exp_wq.size());
        for (int i = 0; i < exp_wq.size() && i < act_wq.size(); i++)
            chk($sformatf("%s_write%0d_cyc_addr_data", tag, i),
                act_wq[i].cyc * 65536 + act_wq[i].addr * 256 + act_wq[i].data,
                exp_wq[i].cyc * 65536 + exp_wq[i].addr * 256 + exp_wq[i].data);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_err"}, err_after, exp_err);
        chk({tag, "_busy_profile_bad"}, busy_bad, 0);
        chk({tag, "_ready_profile_bad"}, ready_bad, 0);
        chk({tag, "_bus_rule_bad"}, rule_bad, 0);
        chk({tag, "_reads"}, rd_cnt, exp_reads);
        chk({tag, "_regfile_bad"}, rf_bad, 0);
        if (v.exp_done >= 0) begin
            chk({tag, "_tbl_done"}, done_cyc, v.exp_done);
            chk({tag, "_tbl_err"}, int'(o_err), v.exp_err);
            chk({tag, "_tbl_writes"}, act_wq.size(), v.exp_writes);
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 8'h81, 8'h00, 0, 0, -1, VFY ? 18 : 10, 0, 9};
        vecs[1] = '{1, 8'h3C, 8'h01, 0, 0, -1, VFY ? 25 : 17, 0, 9};
        vecs[2] = '{2, 8'h55, 8'hA0, 0, 0, -1, 260, 1, 4};
        vecs[3] = '{0, 8'h81, 8'h00, 1, 0, -1, VFY ? 18 : 10, 0, 9};
        vecs[4] = '{0, 8'h81, 8'h00, 0, 0, 6, -1, 0, 0};
        vecs[5] = '{0, 8'h81, 8'h00, 0, 0, -1, VFY ? 18 : 10, 0, 9};
        vecs[6] = '{0, 8'h81, 8'h00, 0, 1, -1, VFY ? 18 : 10, VFY ? 1 : 0, 9};
        for (int i = 7; i < 10; i++)
            vecs[i] = '{3, 8'($urandom), 8'h00, (i == 8), 0, -1, -1, 0, 0};

        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", outs(), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) chk("post_reset_idle", outs(), 0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            repeat (2) @(posedge clk);
        end

        // Valid outside LOAD must not raise ready or cause writes.
        @(posedge clk); #1 i_coeff_valid = 1'b1;
        @(negedge clk) chk("idle_valid_ignored", outs(), int'(o_err) << 8 + 8);
        i_coeff_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
